sv_stream_feeder: RTL and testbench

- Upstream neighbour of the SVM classifier stage.
- Holds the support-vector table (alpha, x, y) written by the trainer.
- Accepts one test sample at a time over a valid/ready handshake.
- For each accepted sample, streams every stored support vector, one per beat, paired with the latched test value, so the classifier accumulates alpha·y·K(x_test, x_sv) over the table.

---
 rtl/svm_pkg.sv | 22 ++
 rtl/sv_table_ram.sv | 18 +
 rtl/sv_stream_feeder.sv | 167 ++++++++++++++++
 tb/tb_sv_stream_feeder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared types and sizing for the SVM support-vector feeder and its table RAM.
package svm_pkg;
    localparam int N_SV = 100;
    localparam int AW   = 9;
    localparam int XW   = 9;
    localparam int IW   = 7;

    typedef struct packed {
        logic [AW-1:0] alpha;
        logic [XW-1:0] x;
        logic [1:0]    y;
    } sv_entry_t;

    // One table entry travelling through the output pipeline with its framing flags.
    typedef struct packed {
        sv_entry_t e;
        logic      first;
        logic      last;
    } sv_beat_t;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} feed_state_e;
endpackage

// File: rtl/sv_table_ram.sv
// Support-vector table: one synchronous write port, one registered read port, no reset.
module sv_table_ram
    import svm_pkg::*;
(
    input  logic            clk,
    input  logic            we_i,
    input  logic [IW-1:0]   waddr_i,
    input  sv_entry_t       wdata_i,
    input  logic [IW-1:0]   raddr_i,
    output sv_entry_t       rdata_o
);
    sv_entry_t mem_q [N_SV];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/sv_stream_feeder.sv
// Streams the whole support-vector table, paired with a latched test feature, once per
// accepted sample; output register plus skid slot keeps beats stable across stalls.
module sv_stream_feeder
    import svm_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_addr,
    input  logic [AW-1:0]   wr_alpha,
    input  logic [XW-1:0]   wr_x,
    input  logic [1:0]      wr_y,
    input  logic            cfg_commit,
    input  logic [IW:0]     cfg_count,
    output logic            wr_err,
    input  logic            test_valid,
    input  logic [XW-1:0]   test_x,
    output logic            test_ready,
    output logic            sv_valid,
    input  logic            sv_ready,
    output logic [AW-1:0]   sv_alpha,
    output logic [XW-1:0]   sv_x,
    output logic [1:0]      sv_y,
    output logic [XW-1:0]   sv_test_x,
    output logic            sv_first,
    output logic            sv_last
);
    localparam logic [IW:0] NSV_W = (IW+1)'(N_SV);

    feed_state_e   state_q, state_d;
    logic [IW:0]   cnt_q, cnt_d, scnt_q, scnt_d, idx_q, idx_d;
    logic [XW-1:0] tx_q, tx_d;
    logic          rd_vld_q, rd_first_q, rd_first_d, rd_last_q, rd_last_d;
    logic          head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
    sv_beat_t      head_q, head_d, skid_q, skid_d, in_beat;
    logic          wr_err_q, wr_err_d;
    logic          we, issue, pop, accept;
    logic [IW-1:0] raddr;
    logic [1:0]    occ;
    sv_entry_t     rdata;

    sv_table_ram u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_addr),
        .wdata_i ('{alpha: wr_alpha, x: wr_x, y: wr_y}),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign accept = (state_q == IDLE) && (cnt_q != '0) && test_valid;
    assign pop    = head_vld_q && sv_ready;
    // Entries held or in flight once this cycle's pop retires; reads only issue while a slot is free.
    assign occ    = 2'(head_vld_q) + 2'(skid_vld_q) + 2'(rd_vld_q) - 2'(pop);
    assign we     = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < NSV_W);
    assign in_beat = '{e: rdata, first: rd_first_q, last: rd_last_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scnt_d     = scnt_q;
        idx_d      = idx_q;
        tx_d       = tx_q;
        issue      = 1'b0;
        raddr      = '0;
        rd_first_d = 1'b0;
        rd_last_d  = 1'b0;
        wr_err_d   = wr_en && !we;

        if (cfg_commit) begin
            if (state_q != IDLE) begin
                wr_err_d = 1'b1;
            end else if (cfg_count > NSV_W) begin
                cnt_d    = NSV_W;
                wr_err_d = 1'b1;
            end else begin
                cnt_d = cfg_count;
            end
        end

        case (state_q)
            IDLE: if (accept) begin
                // Stream length is frozen here so a same-cycle commit only affects the next sample.
                state_d    = STREAM;
                tx_d       = test_x;
                scnt_d     = cnt_q;
                issue      = 1'b1;
                idx_d      = (IW+1)'(1);
                rd_first_d = 1'b1;
                rd_last_d  = (cnt_q == (IW+1)'(1));
            end
            STREAM: begin
                if ((idx_q < scnt_q) && (occ < 2'd2)) begin
                    issue     = 1'b1;
                    raddr     = idx_q[IW-1:0];
                    idx_d     = idx_q + (IW+1)'(1);
                    rd_last_d = (idx_q == scnt_q - (IW+1)'(1));
                end
                if (pop && head_q.last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!head_vld_q || pop) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                head_vld_d = 1'b1;
                skid_vld_d = rd_vld_q;
                if (rd_vld_q) skid_d = in_beat;
            end else begin
                head_vld_d = rd_vld_q;
                if (rd_vld_q) head_d = in_beat;
            end
        end else if (rd_vld_q) begin
            skid_d     = in_beat;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            scnt_q     <= '0;
            idx_q      <= '0;
            tx_q       <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scnt_q     <= scnt_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            rd_vld_q   <= issue;
            rd_first_q <= rd_first_d;
            rd_last_q  <= rd_last_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign test_ready = (state_q == IDLE) && (cnt_q != '0);
    assign sv_valid   = head_vld_q;
    assign sv_alpha   = head_q.e.alpha;
    assign sv_x       = head_q.e.x;
    assign sv_y       = head_q.e.y;
    assign sv_test_x  = tx_q;
    assign sv_first   = head_vld_q && head_q.first;
    assign sv_last    = head_vld_q && head_q.last;
    assign wr_err     = wr_err_q;
endmodule

// File: tb/tb_sv_stream_feeder.sv
// Directed bench for sv_stream_feeder: table-driven write/commit vectors plus stream sequences.
module tb_sv_stream_feeder;
    import svm_pkg::*;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            wr_en = 1'b0;
    logic [IW-1:0]   wr_addr = '0;
    logic [AW-1:0]   wr_alpha = '0;
    logic [XW-1:0]   wr_x = '0;
    logic [1:0]      wr_y = '0;
    logic            cfg_commit = 1'b0;
    logic [IW:0]     cfg_count = '0;
    logic            wr_err;
    logic            test_valid = 1'b0;
    logic [XW-1:0]   test_x = '0;
    logic            test_ready;
    logic            sv_valid;
    logic            sv_ready = 1'b1;
    logic [AW-1:0]   sv_alpha;
    logic [XW-1:0]   sv_x;
    logic [1:0]      sv_y;
    logic [XW-1:0]   sv_test_x;
    logic            sv_first;
    logic            sv_last;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] m_alpha [N_SV];
    logic [XW-1:0] m_x     [N_SV];
    logic [1:0]    m_y     [N_SV];

    typedef struct {
        logic          we;
        logic [IW-1:0] addr;
        logic [AW-1:0] alpha;
        logic [XW-1:0] x;
        logic [1:0]    y;
        logic          cm;
        logic [IW:0]   cnt;
        logic          exp_err;
        logic          exp_rdy;
    } wvec_t;

    wvec_t vt [7];

    sv_stream_feeder dut (
        .clk(clk), .resetn(resetn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_alpha(wr_alpha), .wr_x(wr_x), .wr_y(wr_y),
        .cfg_commit(cfg_commit), .cfg_count(cfg_count), .wr_err(wr_err),
        .test_valid(test_valid), .test_x(test_x), .test_ready(test_ready),
        .sv_valid(sv_valid), .sv_ready(sv_ready), .sv_alpha(sv_alpha), .sv_x(sv_x), .sv_y(sv_y),
        .sv_test_x(sv_test_x), .sv_first(sv_first), .sv_last(sv_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_test_ready"}, 64'(test_ready), 64'd0);
        chk({tag, "_sv_valid"},   64'(sv_valid),   64'd0);
        chk({tag, "_first_last"}, 64'({sv_first, sv_last}), 64'd0);
        chk({tag, "_wr_err"},     64'(wr_err),     64'd0);
        chk({tag, "_data"}, 64'({sv_alpha, sv_x, sv_y, sv_test_x}), 64'd0);
    endtask

    task automatic do_write(input int a, input logic [AW-1:0] al, input logic [XW-1:0] x, input logic [1:0] y);
        wr_en = 1'b1; wr_addr = IW'(a); wr_alpha = al; wr_x = x; wr_y = y;
        step();
        wr_en = 1'b0;
        if (a < N_SV) begin m_alpha[a] = al; m_x[a] = x; m_y[a] = y; end
    endtask

    task automatic do_commit(input logic [IW:0] c, input logic exp_err);
        cfg_commit = 1'b1; cfg_count = c;
        step();
        cfg_commit = 1'b0;
        chk("commit_err", 64'(wr_err), 64'(exp_err));
    endtask

    task automatic accept_sample(input logic [XW-1:0] tx, input logic cm, input logic [IW:0] cc);
        int w = 0;
        test_valid = 1'b1; test_x = tx; cfg_commit = cm; cfg_count = cc;
        while (!test_ready && w < 20) begin step(); w++; end
        chk("accept_ready", 64'(test_ready), 64'd1);
        step();
        test_valid = 1'b0; cfg_commit = 1'b0;
    endtask

    // Runs one sample from acceptance to test_ready returning; cyc counts cycles after acceptance.
    task automatic run_sample(input logic [XW-1:0] tx, input int n, input int stall_beat,
                              input bit inject, input logic cm, input logic [IW:0] cc);
        int idx = 0, cyc = 1, last_cyc = -1, stall_left = 3;
        bit fin = 0;
        logic rdy;
        accept_sample(tx, cm, cc);
        while (!fin && cyc < n + 30) begin
            rdy = 1'b1;
            if (idx == stall_beat && sv_valid && stall_left > 0) begin rdy = 1'b0; stall_left--; end
            sv_ready = rdy;
            if (cyc == 1) chk("latency_t1", 64'(sv_valid), 64'd0);
            if (cyc == 2) chk("latency_t2", 64'(sv_valid), 64'd1);
            if (stall_beat < 0 && cyc > 2 && cyc <= n + 1) chk("no_bubble", 64'(sv_valid), 64'd1);
            if (inject && (cyc == 2 || cyc == 3)) chk("busy_err", 64'(wr_err), 64'd1);
            wr_en = 1'b0; cfg_commit = 1'b0;
            if (inject && cyc == 1) begin
                wr_en = 1'b1; wr_addr = 1; wr_alpha = '1; wr_x = '1; wr_y = 2'b11;
            end
            if (inject && cyc == 2) begin cfg_commit = 1'b1; cfg_count = 1; end
            if (sv_valid) begin
                if (idx >= n) chk("extra_beat", 64'(sv_valid), 64'd0);
                else begin
                    chk("beat", 64'({sv_alpha, sv_x, sv_y, sv_test_x, sv_first, sv_last}),
                        64'({m_alpha[idx], m_x[idx], m_y[idx], tx, idx == 0, idx == n - 1}));
                    if (rdy) begin idx++; if (idx == n) last_cyc = cyc; end
                end
            end
            if (last_cyc >= 0 && cyc == last_cyc + 1) chk("rdy_gap", 64'(test_ready), 64'd0);
            if (last_cyc >= 0 && cyc == last_cyc + 2) begin
                chk("rdy_back", 64'(test_ready), 64'd1);
                fin = 1;
            end
            step();
            cyc++;
        end
        wr_en = 1'b0; cfg_commit = 1'b0; sv_ready = 1'b1;
        chk("beat_count", 64'(idx), 64'(n));
        chk("stream_done", 64'(fin), 64'd1);
    endtask

    initial begin
        vt[0] = '{1'b1, 7'd0,   9'd3, 9'd4, 2'b01, 1'b0, 8'd0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 7'd1,   9'd5, 9'd2, 2'b11, 1'b0, 8'd0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 7'd2,   9'd1, 9'd7, 2'b01, 1'b0, 8'd0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 7'd100, 9'd9, 9'd9, 2'b01, 1'b0, 8'd0, 1'b1, 1'b0};
        vt[4] = '{1'b0, 7'd0,   9'd0, 9'd0, 2'b00, 1'b1, 8'd3, 1'b0, 1'b1};
        vt[5] = '{1'b0, 7'd0,   9'd0, 9'd0, 2'b00, 1'b1, 8'd0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 7'd127, 9'd8, 9'd8, 2'b11, 1'b1, 8'd3, 1'b1, 1'b1};

        repeat (3) step();
        check_reset_outs("rst");
        resetn = 1'b1;
        step();

        // Nothing committed yet: offered sample must be refused.
        test_valid = 1'b1; test_x = 9'd6;
        repeat (4) begin
            step();
            chk("cnt0_ready", 64'(test_ready), 64'd0);
            chk("cnt0_valid", 64'(sv_valid), 64'd0);
        end
        test_valid = 1'b0;

        for (int i = 0; i < 7; i++) begin
            wr_en = vt[i].we; wr_addr = vt[i].addr; wr_alpha = vt[i].alpha;
            wr_x = vt[i].x; wr_y = vt[i].y; cfg_commit = vt[i].cm; cfg_count = vt[i].cnt;
            step();
            wr_en = 1'b0; cfg_commit = 1'b0;
            if (vt[i].we && vt[i].addr < N_SV) begin
                m_alpha[vt[i].addr] = vt[i].alpha; m_x[vt[i].addr] = vt[i].x; m_y[vt[i].addr] = vt[i].y;
            end
            chk($sformatf("vec%0d_err", i), 64'(wr_err), 64'(vt[i].exp_err));
            chk($sformatf("vec%0d_rdy", i), 64'(test_ready), 64'(vt[i].exp_rdy));
        end

        run_sample(9'd6, 3, -1, 0, 1'b0, '0);
        run_sample(9'd9, 3, 1, 0, 1'b0, '0);
        run_sample(9'd2, 3, -1, 1, 1'b0, '0);
        run_sample(9'd6, 3, -1, 0, 1'b0, '0);

        // Commit alongside acceptance: old count streams, new count (1) applies next.
        run_sample(9'd4, 3, -1, 0, 1'b1, 8'd1);
        run_sample(9'd8, 1, -1, 0, 1'b0, '0);

        for (int i = 3; i < N_SV; i++) do_write(i, AW'(i * 7), XW'(i * 3 + 1), 2'(i % 4));
        do_commit(8'd120, 1'b1);
        run_sample(9'd5, 100, -1, 0, 1'b0, '0);

        do_commit(8'd3, 1'b0);
        accept_sample(9'd7, 1'b0, '0);
        step();
        step();
        chk("pre_rst_beat1", 64'({sv_valid, sv_alpha}), 64'({1'b1, 9'd5}));
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check_reset_outs("midrst");
        repeat (4) begin
            step();
            chk("midrst_quiet", 64'({sv_valid, test_ready}), 64'd0);
        end
        do_commit(8'd3, 1'b0);
        run_sample(9'd3, 3, -1, 0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
